// File: rtl/intr_arbiter_if.sv
// Signal bundle between interrupt producers, the arbiter and the single consumer.
// The arbiter takes the slave view; the environment driving requests takes the master view.
interface intr_arbiter_if;
    logic [3:0]  req_intr;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  enable;
    logic        intr;
    logic [7:0]  dout;
    logic [1:0]  src_id;
    logic        intr_ack;
    logic [7:0]  svc_cnt;

    modport slave (
        input  req_intr,
        input  req_data,
        input  enable,
        input  intr_ack,
        output req_ack,
        output intr,
        output dout,
        output src_id,
        output svc_cnt
    );

    modport master (
        output req_intr,
        output req_data,
        output enable,
        output intr_ack,
        input  req_ack,
        input  intr,
        input  dout,
        input  src_id,
        input  svc_cnt
    );
endinterface

// File: rtl/intr_arbiter.sv
// Four-channel round-robin interrupt arbiter: grants one requester at a time to a
// single consumer, holds the grant until the consumer acks, then pulses req_ack.
module intr_arbiter (
    input  logic          clk,
    input  logic          reset,
    intr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_q,      state_d;
    logic        intr_q,       intr_d;
    logic [7:0]  dout_q,       dout_d;
    logic [1:0]  src_id_q,     src_id_d;
    logic [3:0]  req_ack_q,    req_ack_d;
    logic [7:0]  svc_cnt_q,    svc_cnt_d;
    logic [1:0]  last_grant_q, last_grant_d;

    logic [3:0]  eligible;
    logic        pick_valid;
    logic [1:0]  pick_idx;

    assign eligible = bus.req_intr & bus.enable;

    // Rotating priority: search starts just above the last granted channel,
    // so a continuously requesting channel waits for at most three others.
    always_comb begin
        logic [1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = last_grant_q;
        cand       = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_q + 2'(i);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so that no
        // path through the case statement leaves one unassigned (no latches).
        state_d      = state_q;
        intr_d       = intr_q;
        dout_d       = dout_q;
        src_id_d     = src_id_q;
        req_ack_d    = '0;
        svc_cnt_d    = svc_cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = BUSY;
                    intr_d       = 1'b1;
                    src_id_d     = pick_idx;
                    dout_d       = bus.req_data[{pick_idx, 3'b000} +: 8];
                    last_grant_d = pick_idx;
                end
            end
            BUSY: begin
                // Grant is frozen here; only the consumer ack moves us on.
                if (bus.intr_ack) begin
                    state_d             = RELEASE;
                    intr_d              = 1'b0;
                    req_ack_d[src_id_q] = 1'b1;
                    svc_cnt_d           = svc_cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                // One dead cycle lets the producer see req_ack and drop its request
                // before the arbiter looks at requests again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                intr_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            intr_q       <= 1'b0;
            dout_q       <= '0;
            src_id_q     <= '0;
            req_ack_q    <= '0;
            svc_cnt_q    <= '0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            intr_q       <= intr_d;
            dout_q       <= dout_d;
            src_id_q     <= src_id_d;
            req_ack_q    <= req_ack_d;
            svc_cnt_q    <= svc_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.intr    = intr_q;
    assign bus.dout    = dout_q;
    assign bus.src_id  = src_id_q;
    assign bus.req_ack = req_ack_q;
    assign bus.svc_cnt = svc_cnt_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: each task drives one scenario and compares
// outputs against hand-computed values, sampling 1 ns after the rising edge.
module tb_intr_arbiter;

    logic clk = 1'b0;
    logic reset;

    intr_arbiter_if bus ();

    intr_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] rr_data [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_intr = '0;
        bus.req_data = '0;
        bus.enable   = '0;
        bus.intr_ack = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input string name);
        bit ok = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.intr === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        total_cnt++;
        if (!ok) $display("FAIL %s: intr never rose within 20 cycles (got %b, want 1)", name, bus.intr);
        else pass_cnt++;
    endtask

    // Acks the current grant and checks the req_ack pulse, then steps into IDLE.
    task automatic ack_txn(input string name, input logic [3:0] exp_ack);
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        total_cnt++;
        if (bus.req_ack !== exp_ack || bus.intr !== 1'b0)
            $display("FAIL %s ack: req_ack=%b intr=%b, want req_ack=%b intr=0", name, bus.req_ack, bus.intr, exp_ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.req_ack !== 4'b0000)
            $display("FAIL %s release: req_ack=%b, want 0000", name, bus.req_ack);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.intr !== 1'b0 || bus.dout !== 8'h00 || bus.src_id !== 2'd0 ||
            bus.req_ack !== 4'h0 || bus.svc_cnt !== 8'h00)
            $display("FAIL reset_values: intr=%b dout=%h src_id=%0d req_ack=%b svc_cnt=%0d, want all 0",
                     bus.intr, bus.dout, bus.src_id, bus.req_ack, bus.svc_cnt);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        bus.enable   = 4'hF;
        bus.req_data = 32'h005A_0000;
        bus.req_intr = 4'b0100;
        #1;
        total_cnt++;
        if (bus.intr !== 1'b0) $display("FAIL single_no_comb: intr=%b before edge, want 0", bus.intr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.intr !== 1'b1 || bus.dout !== 8'h5A || bus.src_id !== 2'd2 || bus.req_ack !== 4'h0)
            $display("FAIL single_grant: intr=%b dout=%h src_id=%0d req_ack=%b, want 1 5a 2 0000",
                     bus.intr, bus.dout, bus.src_id, bus.req_ack);
        else pass_cnt++;
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        total_cnt++;
        if (bus.intr !== 1'b0 || bus.req_ack !== 4'b0100 || bus.svc_cnt !== 8'd1)
            $display("FAIL single_ack: intr=%b req_ack=%b svc_cnt=%0d, want 0 0100 1",
                     bus.intr, bus.req_ack, bus.svc_cnt);
        else pass_cnt++;
        // Requester still high through RELEASE, drops one cycle after the pulse.
        tick();
        total_cnt++;
        if (bus.req_ack !== 4'h0 || bus.intr !== 1'b0 || bus.dout !== 8'h5A || bus.src_id !== 2'd2)
            $display("FAIL single_release: req_ack=%b intr=%b dout=%h src_id=%0d, want 0000 0 5a 2",
                     bus.req_ack, bus.intr, bus.dout, bus.src_id);
        else pass_cnt++;
        bus.req_intr = 4'b0000;
        tick();
        total_cnt++;
        if (bus.intr !== 1'b0) $display("FAIL single_no_regrant: intr=%b, want 0", bus.intr);
        else pass_cnt++;
        bus.intr_ack = 1'b1;
        tick();
        tick();
        tick();
        bus.intr_ack = 1'b0;
        total_cnt++;
        if (bus.svc_cnt !== 8'd1 || bus.req_ack !== 4'h0 || bus.dout !== 8'h5A)
            $display("FAIL single_idle_ack_ignored: svc_cnt=%0d req_ack=%b dout=%h, want 1 0000 5a",
                     bus.svc_cnt, bus.req_ack, bus.dout);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        bus.enable   = 4'hF;
        bus.req_data = 32'hD3C2_B1A0;
        bus.req_intr = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr_wait");
            total_cnt++;
            if (bus.src_id !== exp_seq[k] || bus.dout !== rr_data[exp_seq[k]])
                $display("FAIL rr_grant%0d: src_id=%0d dout=%h, want %0d %h",
                         k, bus.src_id, bus.dout, exp_seq[k], rr_data[exp_seq[k]]);
            else pass_cnt++;
            ack_txn("rr", 4'b0001 << exp_seq[k]);
        end
    endtask

    task automatic test_masking();
        apply_reset();
        bus.enable   = 4'b0010;
        bus.req_data = 32'h0000_2211;
        bus.req_intr = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            wait_grant("mask_wait");
            total_cnt++;
            if (bus.src_id !== 2'd1 || bus.dout !== 8'h22)
                $display("FAIL mask_grant%0d: src_id=%0d dout=%h, want 1 22", k, bus.src_id, bus.dout);
            else pass_cnt++;
            ack_txn("mask", 4'b0010);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        bus.enable   = 4'hF;
        bus.req_data = 32'h0033_0000;
        bus.req_intr = 4'b0100;
        wait_grant("hold_wait");
        bus.req_data = 32'hFFCC_FFFF;
        bus.enable   = 4'b0000;
        bus.req_intr = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (bus.intr !== 1'b1 || bus.dout !== 8'h33 || bus.src_id !== 2'd2)
                $display("FAIL hold_busy%0d: intr=%b dout=%h src_id=%0d, want 1 33 2",
                         k, bus.intr, bus.dout, bus.src_id);
            else pass_cnt++;
        end
        bus.req_intr = 4'b0000;
        bus.intr_ack = 1'b1;
        tick();
        total_cnt++;
        if (bus.req_ack !== 4'b0100 || bus.svc_cnt !== 8'd1)
            $display("FAIL hold_ack: req_ack=%b svc_cnt=%0d, want 0100 1", bus.req_ack, bus.svc_cnt);
        else pass_cnt++;
        tick();
        bus.intr_ack = 1'b0;
        total_cnt++;
        if (bus.req_ack !== 4'b0000 || bus.svc_cnt !== 8'd1)
            $display("FAIL hold_release_ack_ignored: req_ack=%b svc_cnt=%0d, want 0000 1",
                     bus.req_ack, bus.svc_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.enable   = 4'hF;
        bus.req_data = 32'h0000_7700;
        bus.req_intr = 4'b0010;
        wait_grant("rst_busy_wait");
        total_cnt++;
        if (bus.src_id !== 2'd1) $display("FAIL rst_busy_grant: src_id=%0d, want 1", bus.src_id);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.intr !== 1'b0 || bus.req_ack !== 4'h0 || bus.svc_cnt !== 8'd0 ||
            bus.src_id !== 2'd0 || bus.dout !== 8'h00)
            $display("FAIL rst_busy_clear: intr=%b req_ack=%b svc_cnt=%0d src_id=%0d dout=%h, want all 0",
                     bus.intr, bus.req_ack, bus.svc_cnt, bus.src_id, bus.dout);
        else pass_cnt++;
        bus.intr_ack = 1'b1;
        tick();
        total_cnt++;
        if (bus.req_ack !== 4'h0) $display("FAIL rst_busy_no_ack: req_ack=%b, want 0000", bus.req_ack);
        else pass_cnt++;
        bus.intr_ack = 1'b0;
        bus.req_data = 32'hD3C2_B1A0;
        bus.req_intr = 4'hF;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (bus.intr !== 1'b1 || bus.src_id !== 2'd0 || bus.dout !== 8'hA0)
            $display("FAIL rst_busy_first_ch0: intr=%b src_id=%0d dout=%h, want 1 0 a0",
                     bus.intr, bus.src_id, bus.dout);
        else pass_cnt++;
        bus.req_intr = 4'b0010;
        ack_txn("rst_first", 4'b0001);
        wait_grant("rst_rel_wait");
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        total_cnt++;
        if (bus.req_ack !== 4'b0010 || bus.svc_cnt !== 8'd2)
            $display("FAIL rst_rel_ack: req_ack=%b svc_cnt=%0d, want 0010 2", bus.req_ack, bus.svc_cnt);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.req_ack !== 4'h0 || bus.svc_cnt !== 8'd0 || bus.intr !== 1'b0)
            $display("FAIL rst_rel_clear: req_ack=%b svc_cnt=%0d intr=%b, want 0000 0 0",
                     bus.req_ack, bus.svc_cnt, bus.intr);
        else pass_cnt++;
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        bit         timed_out = 0;
        logic [7:0] cnt_at_255 = '0;
        apply_reset();
        bus.enable   = 4'hF;
        bus.req_data = 32'h0000_0042;
        bus.req_intr = 4'b0001;
        for (int k = 0; k < 256; k++) begin
            for (int n = 0; n < 20 && bus.intr !== 1'b1; n++) tick();
            if (bus.intr !== 1'b1) timed_out = 1;
            bus.intr_ack = 1'b1;
            tick();
            bus.intr_ack = 1'b0;
            if (k == 254) cnt_at_255 = bus.svc_cnt;
            tick();
        end
        total_cnt++;
        if (timed_out) $display("FAIL wrap_grants: a grant timed out (got timeout, want none)");
        else pass_cnt++;
        total_cnt++;
        if (cnt_at_255 !== 8'd255) $display("FAIL wrap_255: svc_cnt=%0d, want 255", cnt_at_255);
        else pass_cnt++;
        total_cnt++;
        if (bus.svc_cnt !== 8'd0) $display("FAIL wrap_zero: svc_cnt=%0d, want 0", bus.svc_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/intr_arbiter.md
INTR_ARBITER -- requirements
Module: intr_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req_intr  in  4  per-channel interrupt request; level, held high until acknowledged.
REQ-004 SHALL have ports: req_data  in  32  per-channel 8-bit data; channel k on bits [8k+7:8k].
REQ-005 SHALL have ports: req_ack  out  4  per-channel acknowledge; registered one-cycle pulse.
REQ-006 SHALL have ports: enable  in  4  per-channel enable; 1 = channel may be granted.
REQ-007 SHALL have ports: intr  out  1  consumer-side interrupt; registered.
REQ-008 SHALL have ports: dout  out  8  data of the granted channel; registered.
REQ-009 SHALL have ports: src_id  out  2  index of the granted channel; registered.
REQ-010 SHALL have ports: intr_ack  in  1  consumer acknowledge; level, sampled on clk.
REQ-011 SHALL have ports: svc_cnt  out  8  count of completed transactions.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-013 IDLE: eligible = req_intr & enable; if eligible nonzero, SHALL pick the first set bit searching upward from last_grant+1 (mod 4), then at the edge load src_id, load dout from that channel's req_data slice, set intr=1, set last_grant=picked index, go to BUSY.
REQ-014 IDLE with eligible == 0 SHALL remain in IDLE with all outputs held.
REQ-015 Latency: request eligible in cycle n SHALL produce intr=1 with valid dout/src_id in cycle n+1.
REQ-016 BUSY: intr, dout, src_id SHALL hold; when intr_ack=1, at the edge clear intr, set req_ack[src_id]=1, increment svc_cnt, go to RELEASE.
REQ-017 RELEASE: SHALL last exactly one cycle; at the edge clear req_ack to 0 and go to IDLE; intr_ack ignored.
REQ-018 intr_ack SHALL be ignored in IDLE and RELEASE.
REQ-019 Changes to enable or req_intr while in BUSY SHALL NOT abort or alter the current grant.
REQ-020 dout and src_id SHALL retain the last granted values after RELEASE until the next grant.
REQ-021 At most one req_ack bit SHALL be high in any cycle.
REQ-022 svc_cnt SHALL wrap 255 -> 0 without any flag.
REQ-023 Minimum transaction length SHALL be 3 cycles (grant, ack, release); a channel dropping req_intr one cycle after its req_ack pulse SHALL NOT be re-granted.
REQ-024 Simultaneous requests SHALL be served round-robin; a continuously requesting channel SHALL wait at most 3 other grants.

Reset
REQ-025 reset low SHALL immediately force: state IDLE, intr=0, dout=0, src_id=0, req_ack=0, svc_cnt=0, last_grant=3 (channel 0 searched first).
REQ-026 Reset asserted mid-BUSY or mid-RELEASE SHALL discard the transaction, with no req_ack pulse issued.
REQ-027 First grant after reset release SHALL occur no earlier than the first rising edge with reset high.

Verification
REQ-028 Single request: enable=4'hF, req_intr=4'b0100, ch2 data 8'h5A -> next cycle intr=1, dout=8'h5A, src_id=2; intr_ack 1 cycle -> req_ack=4'b0100 for one cycle, svc_cnt=1.
REQ-029 Round-robin: after reset, req_intr=4'hF held, each grant acked immediately -> src_id sequence 0,1,2,3,0.
REQ-030 Masking: req_intr=4'b0011, enable=4'b0010 -> only channel 1 granted; channel 0 never gets req_ack.
REQ-031 Hold: in BUSY, change req_data of the granted channel and drop enable -> dout, src_id, and intr unchanged until intr_ack.
REQ-032 Reset mid-BUSY: grant ch1, assert reset before intr_ack -> intr=0, req_ack=0, svc_cnt=0; after release, ch0 searched first.
REQ-033 Wrap: 256 completed transactions -> svc_cnt returns to 0.
